rotary_valve_sequencer: RTL and testbench

- Clocked pneumatic-valve sequencer for the rotary-mixer cell-trap array.
- Drives the control lines of the input 4-way MUX, the rotary mixer (inlet valve, three ring valves, outlet valve) and the output 4-way MUX.
- Each accepted command runs one batch: load from a selected source port, peristaltically mix N rotations, then drain to a selected cell trap.
- Sits between the host command interface and the chip's control-port pins (cb*).

---
 rtl/rotary_seq_pkg.sv | 32 +++
 rtl/rotary_dwell_timer.sv | 26 ++
 rtl/rotary_valve_sequencer.sv | 196 +++++++++++++++++++
 tb/tb_rotary_valve_sequencer.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/rotary_seq_pkg.sv
// Shared types, valve-line constants and decode helpers for the rotary valve sequencer.
package rotary_seq_pkg;

    typedef enum logic [1:0] {IDLE, LOAD, MIX, DRAIN} state_t;

    // A line at 1 is pressurised, which closes its valve.
    localparam logic [3:0] CLOSED_MUX = 4'b1111;
    localparam logic [4:0] CLOSED_MIX = 5'b11111;
    localparam logic [4:0] LOAD_MIX   = 5'b10000;
    localparam logic [4:0] DRAIN_MIX  = 5'b00001;

    // Peristaltic ring pattern per phase, stored as {port4,port5,port6}.
    localparam logic [2:0] RING_PAT [6] = '{3'b101, 3'b100, 3'b110, 3'b010, 3'b011, 3'b001};

    // Outlets are paired by the MUX topology, so only k[1] changes the lines.
    function automatic logic [3:0] mux_decode(input logic [1:0] k);
        logic [3:0] lines;
        case (k)
            2'd0, 2'd1: lines = 4'b1010;
            default:    lines = 4'b0101;
        endcase
        return lines;
    endfunction

    // Mixer word {port7,port6,port5,port4,port3} during MIX for a given phase.
    function automatic logic [4:0] mix_ring(input logic [2:0] ph);
        logic [2:0] p;
        p = (ph <= 3'd5) ? RING_PAT[ph] : 3'b111;
        return {1'b1, p[0], p[1], p[2], 1'b1};
    endfunction

endpackage

// File: rtl/rotary_dwell_timer.sv
// Loadable down-counter with an expiry flag; a load of N gives an N-cycle dwell.
module rotary_dwell_timer #(
    parameter int TICK_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              load,
    input  logic [TICK_W-1:0] load_val,
    output logic              expired
);

    logic [TICK_W-1:0] cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= load_val - TICK_W'(1);
        end else if (cnt_q != '0) begin
            cnt_q <= cnt_q - TICK_W'(1);
        end
    end

    assign expired = (cnt_q == '0);

endmodule

// File: rtl/rotary_valve_sequencer.sv
// Batch sequencer for the rotary-mixer cell-trap array: load, peristaltic mix, drain.
// Optional macro ROTARY_SEQ_REVERSE_EN adds cmd_dir for reverse pumping.
module rotary_valve_sequencer
    import rotary_seq_pkg::*;
#(
    parameter int TICK_W      = 16,
    parameter int LOAD_TICKS  = 1000,
    parameter int PHASE_TICKS = 50,
    parameter int DRAIN_TICKS = 1000,
    parameter int CYC_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [1:0]       cmd_src,
    input  logic [1:0]       cmd_dst,
    input  logic [CYC_W-1:0] cmd_cycles,
`ifdef ROTARY_SEQ_REVERSE_EN
    input  logic             cmd_dir,
`endif
    input  logic             abort,
    output logic [3:0]       in_mux_ctrl,
    output logic [3:0]       out_mux_ctrl,
    output logic [4:0]       mix_ctrl,
    output logic             busy,
    output logic             done,
    output logic             aborted,
    output logic [2:0]       phase
);

    localparam logic [TICK_W-1:0] LOAD_T  = TICK_W'(LOAD_TICKS);
    localparam logic [TICK_W-1:0] PHASE_T = TICK_W'(PHASE_TICKS);
    localparam logic [TICK_W-1:0] DRAIN_T = TICK_W'(DRAIN_TICKS);

    state_t             state_q, state_d;
    logic [2:0]         phase_q, phase_d;
    logic [CYC_W-1:0]   rot_q, rot_d;
    logic [1:0]         src_q, dst_q, src_sel;
    logic [CYC_W-1:0]   cyc_q;
    logic               rev;
    logic               accept;
    logic               tmr_load, tmr_exp;
    logic [TICK_W-1:0]  tmr_val;
    logic               done_d, aborted_d;
    logic [3:0]         in_d, out_d;
    logic [4:0]         mix_d;

    function automatic logic [2:0] step_phase(input logic [2:0] ph, input logic r);
        if (r) return (ph == 3'd0) ? 3'd5 : ph - 3'd1;
        return (ph == 3'd5) ? 3'd0 : ph + 3'd1;
    endfunction

    assign cmd_ready = (state_q == IDLE) & ~abort;
    assign accept    = cmd_valid & cmd_ready;
    assign src_sel   = (state_q == IDLE) ? cmd_src : src_q;

    // Command fields are plain data: captured on accept, never reset.
    always_ff @(posedge clk) begin
        if (accept) begin
            src_q <= cmd_src;
            dst_q <= cmd_dst;
            cyc_q <= cmd_cycles;
        end
    end

`ifdef ROTARY_SEQ_REVERSE_EN
    logic dir_q;
    always_ff @(posedge clk) begin
        if (accept) dir_q <= cmd_dir;
    end
    assign rev = dir_q;
`else
    assign rev = 1'b0;
`endif

    rotary_dwell_timer #(.TICK_W(TICK_W)) u_dwell (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .expired  (tmr_exp)
    );

    always_comb begin
        state_d   = state_q;
        phase_d   = phase_q;
        rot_d     = rot_q;
        tmr_load  = 1'b0;
        tmr_val   = LOAD_T;
        done_d    = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    state_d  = LOAD;
                    tmr_load = 1'b1;
                    tmr_val  = LOAD_T;
                end
            end
            LOAD: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (tmr_exp) begin
                    tmr_load = 1'b1;
                    phase_d  = 3'd0;
                    rot_d    = '0;
                    if (cyc_q != '0) begin
                        state_d = MIX;
                        tmr_val = PHASE_T;
                    end else begin
                        state_d = DRAIN;
                        tmr_val = DRAIN_T;
                    end
                end
            end
            MIX: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                    phase_d   = 3'd0;
                end else if (tmr_exp) begin
                    tmr_load = 1'b1;
                    tmr_val  = PHASE_T;
                    phase_d  = step_phase(phase_q, rev);
                    // Last phase of a rotation: either count it or leave for DRAIN.
                    if (phase_q == (rev ? 3'd1 : 3'd5)) begin
                        if (rot_q == cyc_q - CYC_W'(1)) begin
                            state_d = DRAIN;
                            tmr_val = DRAIN_T;
                            phase_d = 3'd0;
                        end else begin
                            rot_d = rot_q + CYC_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                if (abort) begin
                    state_d   = IDLE;
                    aborted_d = 1'b1;
                end else if (tmr_exp) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        in_d  = CLOSED_MUX;
        out_d = CLOSED_MUX;
        mix_d = CLOSED_MIX;
        case (state_d)
            LOAD: begin
                in_d  = mux_decode(src_sel);
                mix_d = LOAD_MIX;
            end
            MIX:   mix_d = mix_ring(phase_d);
            DRAIN: begin
                out_d = mux_decode(dst_q);
                mix_d = DRAIN_MIX;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            phase_q      <= 3'd0;
            rot_q        <= '0;
            in_mux_ctrl  <= CLOSED_MUX;
            out_mux_ctrl <= CLOSED_MUX;
            mix_ctrl     <= CLOSED_MIX;
            busy         <= 1'b0;
            done         <= 1'b0;
            aborted      <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            rot_q        <= rot_d;
            in_mux_ctrl  <= in_d;
            out_mux_ctrl <= out_d;
            mix_ctrl     <= mix_d;
            busy         <= (state_d != IDLE);
            done         <= done_d;
            aborted      <= aborted_d;
        end
    end

    assign phase = phase_q;

endmodule

// File: tb/tb_rotary_valve_sequencer.sv
// Directed plus randomized bench for rotary_valve_sequencer against a per-cycle trace model.
module tb_rotary_valve_sequencer;

    localparam int TICK_W = 16;
    localparam int CYC_W  = 8;
    localparam int LT     = 3;
    localparam int PT     = 2;
    localparam int DT     = 3;

    logic             clk = 1'b0;
    logic             rst;
    logic             cmd_valid;
    logic             cmd_ready;
    logic [1:0]       cmd_src, cmd_dst;
    logic [CYC_W-1:0] cmd_cycles;
    logic             abort;
    logic [3:0]       in_mux_ctrl, out_mux_ctrl;
    logic [4:0]       mix_ctrl;
    logic             busy, done, aborted;
    logic [2:0]       phase;
`ifdef ROTARY_SEQ_REVERSE_EN
    logic             cmd_dir = 1'b0;
`endif

    int          tests = 0;
    int          fails = 0;
    int          busy_seen;
    logic [31:0] exp_q[$];
    int          pat[6] = '{5, 4, 6, 2, 3, 1};

    always #5 clk = ~clk;

    rotary_valve_sequencer #(
        .TICK_W(TICK_W), .LOAD_TICKS(LT), .PHASE_TICKS(PT), .DRAIN_TICKS(DT), .CYC_W(CYC_W)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .cmd_valid    (cmd_valid),
        .cmd_ready    (cmd_ready),
        .cmd_src      (cmd_src),
        .cmd_dst      (cmd_dst),
        .cmd_cycles   (cmd_cycles),
`ifdef ROTARY_SEQ_REVERSE_EN
        .cmd_dir      (cmd_dir),
`endif
        .abort        (abort),
        .in_mux_ctrl  (in_mux_ctrl),
        .out_mux_ctrl (out_mux_ctrl),
        .mix_ctrl     (mix_ctrl),
        .busy         (busy),
        .done         (done),
        .aborted      (aborted),
        .phase        (phase)
    );

    function automatic logic [31:0] pack(input logic b, input logic d, input logic a,
                                         input logic [2:0] ph, input logic [3:0] im,
                                         input logic [3:0] om, input logic [4:0] mx);
        return {13'd0, b, d, a, ph, im, om, mx};
    endfunction

    function automatic logic [31:0] obs();
        return pack(busy, done, aborted, phase, in_mux_ctrl, out_mux_ctrl, mix_ctrl);
    endfunction

    // {ctrl4,ctrl3,ctrl2,ctrl1}: ctrl1/ctrl3 follow k[1], ctrl2/ctrl4 are its inverse.
    function automatic logic [3:0] mux_exp(input logic [1:0] k);
        logic k1;
        k1 = k[1];
        return {~k1, k1, ~k1, k1};
    endfunction

    function automatic logic [4:0] ring_exp(input int p);
        logic [2:0] b;
        b = 3'(pat[p]);
        return {1'b1, b[0], b[1], b[2], 1'b1};
    endfunction

    function automatic logic [31:0] idle_w();
        return pack(1'b0, 1'b0, 1'b0, 3'd0, 4'hF, 4'hF, 5'h1F);
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        tests++;
        assert (got === want) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, want);
        end
    endtask

    // Expected output word for every cycle from the first LOAD cycle through the done cycle.
    task automatic build(input logic [1:0] s, input logic [1:0] d, input int c);
        exp_q.delete();
        for (int t = 0; t < LT; t++) exp_q.push_back(pack(1, 0, 0, 0, mux_exp(s), 4'hF, 5'b10000));
        for (int r = 0; r < c; r++)
            for (int p = 0; p < 6; p++)
                for (int t = 0; t < PT; t++)
                    exp_q.push_back(pack(1, 0, 0, 3'(p), 4'hF, 4'hF, ring_exp(p)));
        for (int t = 0; t < DT; t++) exp_q.push_back(pack(1, 0, 0, 0, 4'hF, mux_exp(d), 5'b00001));
        exp_q.push_back(pack(0, 1, 0, 0, 4'hF, 4'hF, 5'h1F));
    endtask

    task automatic present(input logic [1:0] s, input logic [1:0] d, input int c);
        cmd_valid  = 1'b1;
        cmd_src    = s;
        cmd_dst    = d;
        cmd_cycles = CYC_W'(c);
        #1;
        check("ready_idle", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        cmd_valid = 1'b0;
    endtask

    // Called at the negedge showing the first LOAD cycle; returns at the done or aborted cycle.
    task automatic follow(input logic [1:0] s, input logic [1:0] d, input int c,
                          input int abort_at, input bit hold);
        build(s, d, c);
        busy_seen = 0;
        for (int i = 0; i < exp_q.size(); i++) begin
            check("trace", obs(), exp_q[i]);
            if (busy) busy_seen++;
            if (hold) check("ready_hold", 32'(cmd_ready), 32'(i == exp_q.size() - 1));
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                check("abort_taken", obs(), pack(0, 0, 1, 0, 4'hF, 4'hF, 5'h1F));
                abort = 1'b0;
                return;
            end
            if (i != exp_q.size() - 1) @(negedge clk);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [1:0] s, d;
        int c, len, ab;

        rst        = 1'b1;
        cmd_valid  = 1'b0;
        cmd_src    = 2'd0;
        cmd_dst    = 2'd0;
        cmd_cycles = '0;
        abort      = 1'b0;
        #12;
        check("reset_outputs", obs(), idle_w());
        check("reset_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Reference batch: in_mux 0101, full ring, out_mux 1010, 18 busy clocks.
        present(2'd2, 2'd1, 1);
        follow(2'd2, 2'd1, 1, -1, 1'b0);
        check("batch_len", 32'(busy_seen), 32'd18);
        @(negedge clk);
        check("done_width", obs(), idle_w());

        // No mixing: LOAD straight into DRAIN.
        present(2'd0, 2'd3, 0);
        follow(2'd0, 2'd3, 0, -1, 1'b0);
        check("nomix_len", 32'(busy_seen), 32'd6);
        @(negedge clk);

        // Held command is taken only on the done cycle.
        cmd_valid  = 1'b1;
        cmd_src    = 2'd1;
        cmd_dst    = 2'd2;
        cmd_cycles = CYC_W'(1);
        @(negedge clk);
        cmd_src    = 2'd3;
        cmd_dst    = 2'd0;
        cmd_cycles = CYC_W'(2);
        follow(2'd1, 2'd2, 1, -1, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0;
        follow(2'd3, 2'd0, 2, -1, 1'b0);
        @(negedge clk);
        check("after_b2b", obs(), idle_w());

        // Abort in the third MIX cycle, then immediate re-accept.
        present(2'd2, 2'd2, 1);
        follow(2'd2, 2'd2, 1, LT + 2, 1'b0);
        present(2'd1, 2'd1, 0);
        follow(2'd1, 2'd1, 0, -1, 1'b0);
        @(negedge clk);

        // Abort on the last DRAIN tick beats done.
        present(2'd0, 2'd0, 1);
        follow(2'd0, 2'd0, 1, LT + 6 * PT + DT - 1, 1'b0);
        @(negedge clk);
        check("abort_no_done", obs(), idle_w());

        // Abort while idle only blocks acceptance.
        abort     = 1'b1;
        cmd_valid = 1'b1;
        #1;
        check("idle_abort_ready", 32'(cmd_ready), 32'd0);
        @(negedge clk);
        check("idle_abort_state", obs(), idle_w());
        abort     = 1'b0;
        cmd_valid = 1'b0;
        @(negedge clk);

        // Asynchronous reset in the middle of DRAIN.
        present(2'd0, 2'd3, 1);
        for (int i = 0; i < LT + 6 * PT + 1; i++) @(negedge clk);
        check("mid_drain", obs(), pack(1, 0, 0, 0, 4'hF, mux_exp(2'd3), 5'b00001));
        #2 rst = 1'b1;
        #1;
        check("async_rst", obs(), idle_w());
        check("async_rst_ready", 32'(cmd_ready), 32'd1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Randomized batches, some aborted at a random busy cycle.
        for (int n = 0; n < 14; n++) begin
            s   = 2'($urandom_range(0, 3));
            d   = 2'($urandom_range(0, 3));
            c   = int'($urandom_range(0, 3));
            len = LT + 6 * PT * c + DT + 1;
            ab  = ($urandom_range(0, 2) == 0) ? int'($urandom_range(0, len - 2)) : -1;
            present(s, d, c);
            follow(s, d, c, ab, 1'b0);
            @(negedge clk);
            check("rand_idle", obs(), idle_w());
        end

        // Maximum rotation count.
        present(2'd3, 2'd1, 255);
        follow(2'd3, 2'd1, 255, -1, 1'b0);
        check("max_len", 32'(busy_seen), 32'(LT + 6 * PT * 255 + DT));
        @(negedge clk);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
